rr_alu_sequencer: RTL and testbench
===================================

// Module: rr_alu_sequencer
// PURPOSE
//  Hardwired control-step sequencer for register-register ALU instructions on the phase-1
//  bus datapath. Generates the T0..T6 fetch/execute strobes (PC, MAR, MDR, IR, Y, Z, HI/LO, GPR)
//  that the phase-1 benches currently drive by hand. Generalised beyond a single ALU op:
//  - parametrised register file and instruction width
//  - memory-ready wait states with timeout
//  - unary ops and two-result ops (MUL/DIV to HI/LO)
// PARAMETERS
//  INSTR_W     32      instruction width; IR field order MSB-first: opcode, Ra, Rb, Rc
//  OPC_W       5       opcode field width
//  REG_ADDR_W  4       GPR index width; NUM_REGS = 2**REG_ADDR_W
//  OP_MUL      5'b01111  opcode writing Z to LO then HI
//  OP_DIV      5'b10000  opcode writing Z to LO then HI
//  OP_NEG      5'b10001  unary opcode (Rb only)
//  OP_NOT      5'b10010  unary opcode (Rb only)
//  TIMEOUT     15      max T1 wait cycles; counter width $clog2(TIMEOUT+1)
// PORTS
//  Clock        in   1          rising-edge clock
//  Reset        in   1          async active-high reset
//  Start        in   1          begin instruction; sampled in IDLE only
//  MemReady     in   1          memory data valid on Mdatain this cycle
//  IR           in   INSTR_W    datapath IR contents; valid from T3 onward
//  PCout,MARin,IncrementPC,Zin,ZLOout,ZHIout,PCin,Read,MDRin,MDRout,IRin,Yin,LOin,HIin
//               out  1 each     datapath strobes
//  Rin          out  NUM_REGS   one-hot GPR load enable
//  Rout         out  NUM_REGS   one-hot GPR bus drive enable
//  ALUControl   out  OPC_W      ALU op select
//  Busy         out  1          high in every state except IDLE
//  Done         out  1          one-cycle pulse, instruction retired
//  Fault        out  1          one-cycle pulse, memory timeout
// BEHAVIOUR
//  - Reset (async): state=IDLE, wait counter=0, every output 0. Reset mid-instruction aborts
//    with no further strobes. No partial GPR/HI/LO write is issued after reset.
//  - Outputs are Moore decodes of the registered state. At most one bus driver is high per cycle.
//  - State sequence: IDLE -> T0 -> T1 -> T2 -> T3 -> T4 -> T5 -> [T6] -> DONE -> IDLE.
//  - IDLE: Start=1 -> T0 next edge. Start in any other state is ignored.
//  - T0: PCout, MARin, IncrementPC, Zin.
//  - T1: ZLOout, PCin, Read, MDRin.
//    - MemReady=0: stay in T1 and increment the counter; strobes are held.
//    - MemReady=1: -> T2 and clear the counter.
//    - MemReady=0 with counter==TIMEOUT: -> FAULT. FAULT asserts Fault for 1 cycle, then -> IDLE.
//  - T2: MDRout, IRin. The IR is captured at the end of T2.
//  - T3: Rout[Rb], Yin.
//  - T4: Zin, ALUControl=IR opcode; Rout[Rc], or Rout[Rb] if unary (OP_NEG/OP_NOT).
//    ALUControl is 0 in all other states.
//  - T5:
//    - MUL/DIV: ZLOout, LOin; -> T6.
//    - Otherwise: ZLOout, Rin[Ra]; -> DONE.
//  - T6 (MUL/DIV only): ZHIout, HIin; -> DONE.
//  - DONE: Done=1, Busy=1; -> IDLE. The next Start is accepted in IDLE.
//    Fastest issue rate is one instruction per 8 cycles, or 9 for MUL/DIV.
//  - Latency, Start to Done with MemReady=1 in T1: 7 cycles, 8 for MUL/DIV.
//    Each wait cycle adds 1.
//  - Ra==Rb==Rc is legal; a single index sets a single one-hot bit.
//  - Index decode is pure: Rout/Rin index = IR field value, no range check.
//  - Counter never exceeds TIMEOUT and does not wrap.
// TESTING
//  1 AND R1,R2,R3: IR=0x28918000, MemReady=1, Start pulse ->
//    T3 Rout=0x0004 Yin; T4 Rout=0x0008 ALUControl=5'b00101 Zin; T5 Rin=0x0002 ZLOout;
//    Done 7 cycles after Start.
//  2 Wait states: MemReady low for 3 cycles in T1 -> Read/MDRin/PCin held 4 cycles;
//    Done at cycle 10; Fault stays 0.
//  3 Timeout: MemReady held 0 -> Fault pulses after TIMEOUT+1 T1 cycles; back to IDLE;
//    no Rin/IRin ever asserted.
//  4 MUL R0,R4,R5 (opcode 01111) -> T5 LOin+ZLOout, T6 HIin+ZHIout; Rin=0 throughout;
//    Done at cycle 8.
//  5 NOT R6,R7 (opcode 10010) -> Rout=0x0080 in both T3 and T4; Rin=0x0040 in T5.
//  6 Reset asserted mid-T4 -> all outputs 0 asynchronously, Busy=0.
//    Start while Busy is ignored; after release, Start runs a full clean sequence.

Source files
------------

// File: rtl/rr_alu_sequencer_if.sv
// Strobe/handshake bundle between the RR-ALU control sequencer and the phase-1 bus datapath.
interface rr_alu_sequencer_if #(
    parameter int INSTR_W    = 32,
    parameter int OPC_W      = 5,
    parameter int REG_ADDR_W = 4
);
    localparam int NUM_REGS = 2 ** REG_ADDR_W;

    logic                Start;
    logic                MemReady;
    logic [INSTR_W-1:0]  IR;
    logic                PCout, MARin, IncrementPC, Zin, ZLOout, ZHIout, PCin;
    logic                Read, MDRin, MDRout, IRin, Yin, LOin, HIin;
    logic [NUM_REGS-1:0] Rin;
    logic [NUM_REGS-1:0] Rout;
    logic [OPC_W-1:0]    ALUControl;
    logic                Busy, Done, Fault;

    modport master (
        input  Start, MemReady, IR,
        output PCout, MARin, IncrementPC, Zin, ZLOout, ZHIout, PCin,
               Read, MDRin, MDRout, IRin, Yin, LOin, HIin,
               Rin, Rout, ALUControl, Busy, Done, Fault
    );

    modport slave (
        output Start, MemReady, IR,
        input  PCout, MARin, IncrementPC, Zin, ZLOout, ZHIout, PCin,
               Read, MDRin, MDRout, IRin, Yin, LOin, HIin,
               Rin, Rout, ALUControl, Busy, Done, Fault
    );
endinterface

// File: rtl/rr_alu_sequencer.sv
// Hardwired T0..T6 control-step sequencer for register-register ALU instructions.
// Outputs are pure Moore decodes of the registered state, so reset clears them at once.
module rr_alu_sequencer #(
    parameter int             INSTR_W    = 32,
    parameter int             OPC_W      = 5,
    parameter int             REG_ADDR_W = 4,
    parameter logic [OPC_W-1:0] OP_MUL   = 5'b01111,
    parameter logic [OPC_W-1:0] OP_DIV   = 5'b10000,
    parameter logic [OPC_W-1:0] OP_NEG   = 5'b10001,
    parameter logic [OPC_W-1:0] OP_NOT   = 5'b10010,
    parameter int             TIMEOUT    = 15
) (
    input logic              Clock,
    input logic              Reset,
    rr_alu_sequencer_if.master bus
);
    localparam int NUM_REGS = 2 ** REG_ADDR_W;
    localparam int CNT_W    = $clog2(TIMEOUT + 1);
    localparam int RA_LSB   = INSTR_W - OPC_W - REG_ADDR_W;
    localparam int RB_LSB   = RA_LSB - REG_ADDR_W;
    localparam int RC_LSB   = RB_LSB - REG_ADDR_W;

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_T0    = 4'd1;
    localparam logic [3:0] S_T1    = 4'd2;
    localparam logic [3:0] S_T2    = 4'd3;
    localparam logic [3:0] S_T3    = 4'd4;
    localparam logic [3:0] S_T4    = 4'd5;
    localparam logic [3:0] S_T5    = 4'd6;
    localparam logic [3:0] S_T6    = 4'd7;
    localparam logic [3:0] S_DONE  = 4'd8;
    localparam logic [3:0] S_FAULT = 4'd9;

    logic [3:0]            state, next_state;
    logic [CNT_W-1:0]      wait_cnt;
    logic [OPC_W-1:0]      opc;
    logic [REG_ADDR_W-1:0] ra, rb, rc;
    logic                  two_result, unary, cnt_expired;

    assign opc         = bus.IR[INSTR_W-1 -: OPC_W];
    assign ra          = bus.IR[RA_LSB +: REG_ADDR_W];
    assign rb          = bus.IR[RB_LSB +: REG_ADDR_W];
    assign rc          = bus.IR[RC_LSB +: REG_ADDR_W];
    assign two_result  = (opc == OP_MUL) || (opc == OP_DIV);
    assign unary       = (opc == OP_NEG) || (opc == OP_NOT);
    assign cnt_expired = (wait_cnt == CNT_W'(TIMEOUT));

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (bus.Start) next_state = S_T0;
            S_T0:    next_state = S_T1;
            S_T1: begin
                if (bus.MemReady)    next_state = S_T2;
                else if (cnt_expired) next_state = S_FAULT;
            end
            S_T2:    next_state = S_T3;
            S_T3:    next_state = S_T4;
            S_T4:    next_state = S_T5;
            S_T5:    next_state = two_result ? S_T6 : S_DONE;
            S_T6:    next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            S_FAULT: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // The wait counter only runs while T1 stalls; it is cleared on either exit from T1.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            state <= next_state;
            if (state == S_T1) begin
                if (bus.MemReady || cnt_expired) wait_cnt <= '0;
                else                             wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        bus.PCout       = 1'b0;
        bus.MARin       = 1'b0;
        bus.IncrementPC = 1'b0;
        bus.Zin         = 1'b0;
        bus.ZLOout      = 1'b0;
        bus.ZHIout      = 1'b0;
        bus.PCin        = 1'b0;
        bus.Read        = 1'b0;
        bus.MDRin       = 1'b0;
        bus.MDRout      = 1'b0;
        bus.IRin        = 1'b0;
        bus.Yin         = 1'b0;
        bus.LOin        = 1'b0;
        bus.HIin        = 1'b0;
        bus.Rin         = '0;
        bus.Rout        = '0;
        bus.ALUControl  = '0;
        bus.Busy        = (state != S_IDLE);
        bus.Done        = 1'b0;
        bus.Fault       = 1'b0;
        case (state)
            S_T0: begin
                bus.PCout       = 1'b1;
                bus.MARin       = 1'b1;
                bus.IncrementPC = 1'b1;
                bus.Zin         = 1'b1;
            end
            S_T1: begin
                bus.ZLOout = 1'b1;
                bus.PCin   = 1'b1;
                bus.Read   = 1'b1;
                bus.MDRin  = 1'b1;
            end
            S_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            S_T3: begin
                bus.Rout = NUM_REGS'(1) << rb;
                bus.Yin  = 1'b1;
            end
            S_T4: begin
                bus.Rout       = NUM_REGS'(1) << (unary ? rb : rc);
                bus.Zin        = 1'b1;
                bus.ALUControl = opc;
            end
            S_T5: begin
                bus.ZLOout = 1'b1;
                if (two_result) bus.LOin = 1'b1;
                else            bus.Rin  = NUM_REGS'(1) << ra;
            end
            S_T6: begin
                bus.ZHIout = 1'b1;
                bus.HIin   = 1'b1;
            end
            S_DONE:  bus.Done  = 1'b1;
            S_FAULT: bus.Fault = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_rr_alu_sequencer.sv
// Randomized bench: each instruction is expanded into an expected per-cycle strobe trace.
module tb_rr_alu_sequencer;
    localparam int INSTR_W = 32, OPC_W = 5, REG_ADDR_W = 4, TIMEOUT = 15;
    localparam logic [4:0] OP_MUL = 5'b01111, OP_DIV = 5'b10000;
    localparam logic [4:0] OP_NEG = 5'b10001, OP_NOT = 5'b10010, OP_AND = 5'b00101;

    // Bit positions of the strobe group in the observed word.
    localparam logic [16:0] PCOUT = 17'h10000, MARIN = 17'h08000, INCPC = 17'h04000,
                            ZIN   = 17'h02000, ZLOOUT = 17'h01000, ZHIOUT = 17'h00800,
                            PCIN  = 17'h00400, READ = 17'h00200, MDRIN = 17'h00100,
                            MDROUT = 17'h00080, IRIN = 17'h00040, YIN = 17'h00020,
                            LOIN  = 17'h00010, HIIN = 17'h00008, BUSY = 17'h00004,
                            DONE  = 17'h00002, FAULT = 17'h00001;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   n_cmp = 0, n_bad = 0;

    logic [63:0] exp_q[$];
    bit          st_q[$];
    bit          mr_q[$];

    rr_alu_sequencer_if #(.INSTR_W(INSTR_W), .OPC_W(OPC_W), .REG_ADDR_W(REG_ADDR_W)) bus ();

    rr_alu_sequencer #(.INSTR_W(INSTR_W), .OPC_W(OPC_W), .REG_ADDR_W(REG_ADDR_W),
                       .TIMEOUT(TIMEOUT)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] obs();
        return {10'b0, bus.PCout, bus.MARin, bus.IncrementPC, bus.Zin, bus.ZLOout, bus.ZHIout,
                bus.PCin, bus.Read, bus.MDRin, bus.MDRout, bus.IRin, bus.Yin, bus.LOin,
                bus.HIin, bus.Busy, bus.Done, bus.Fault, bus.Rin, bus.Rout, bus.ALUControl};
    endfunction

    // One cycle of the trace: expected outputs, plus Start/MemReady driven during that cycle.
    // Outside IDLE and T1 both inputs are noise the sequencer must ignore.
    task automatic push(input logic [16:0] s, input logic [15:0] rin, input logic [15:0] rout,
                        input logic [4:0] alu, input bit st, input bit mr);
        exp_q.push_back({10'b0, s, rin, rout, alu});
        st_q.push_back(st);
        mr_q.push_back(mr);
    endtask

    task automatic build(input logic [4:0] opc, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [3:0] rc, input int nwait, input bit tmo);
        logic [16:0] t1s;
        bit md, un;
        md  = (opc == OP_MUL) || (opc == OP_DIV);
        un  = (opc == OP_NEG) || (opc == OP_NOT);
        t1s = ZLOOUT | PCIN | READ | MDRIN | BUSY;
        exp_q.delete(); st_q.delete(); mr_q.delete();
        push(17'h0, 16'h0, 16'h0, 5'h0, 1'b1, 1'($urandom));
        push(PCOUT | MARIN | INCPC | ZIN | BUSY, 16'h0, 16'h0, 5'h0, 1'($urandom), 1'($urandom));
        if (tmo) begin
            for (int i = 0; i <= TIMEOUT; i++) push(t1s, 16'h0, 16'h0, 5'h0, 1'($urandom), 1'b0);
            push(FAULT | BUSY, 16'h0, 16'h0, 5'h0, 1'($urandom), 1'($urandom));
            return;
        end
        for (int i = 0; i < nwait; i++) push(t1s, 16'h0, 16'h0, 5'h0, 1'($urandom), 1'b0);
        push(t1s, 16'h0, 16'h0, 5'h0, 1'($urandom), 1'b1);
        push(MDROUT | IRIN | BUSY, 16'h0, 16'h0, 5'h0, 1'($urandom), 1'($urandom));
        push(YIN | BUSY, 16'h0, 16'h1 << rb, 5'h0, 1'($urandom), 1'($urandom));
        push(ZIN | BUSY, 16'h0, 16'h1 << (un ? rb : rc), opc, 1'($urandom), 1'($urandom));
        if (md) begin
            push(ZLOOUT | LOIN | BUSY, 16'h0, 16'h0, 5'h0, 1'($urandom), 1'($urandom));
            push(ZHIOUT | HIIN | BUSY, 16'h0, 16'h0, 5'h0, 1'($urandom), 1'($urandom));
        end else begin
            push(ZLOOUT | BUSY, 16'h1 << ra, 16'h0, 5'h0, 1'($urandom), 1'($urandom));
        end
        push(DONE | BUSY, 16'h0, 16'h0, 5'h0, 1'($urandom), 1'($urandom));
    endtask

    // Runs one instruction; abort_at >= 0 asserts Reset mid-cycle at that trace index.
    task automatic run(input string tag, input logic [4:0] opc, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [3:0] rc, input logic [14:0] low,
                       input int nwait, input bit tmo, input int abort_at);
        build(opc, ra, rb, rc, nwait, tmo);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge Clock);
            chk($sformatf("%s[%0d]", tag, i), obs(), exp_q[i]);
            if (i == 0) bus.IR = {opc, ra, rb, rc, low};
            bus.Start    = st_q[i];
            bus.MemReady = mr_q[i];
            if (i == abort_at) begin
                #2 Reset = 1'b1;
                #1 chk({tag, "_rst_async"}, obs(), 64'h0);
                bus.Start = 1'b1;
                repeat (2) begin
                    @(negedge Clock);
                    chk({tag, "_rst_hold"}, obs(), 64'h0);
                end
                Reset     = 1'b0;
                bus.Start = 1'b0;
                return;
            end
        end
    endtask

    initial begin
        logic [4:0] opc;
        int pick;
        bus.Start = 1'b0; bus.MemReady = 1'b0; bus.IR = '0;
        #1 chk("reset", obs(), 64'h0);
        @(negedge Clock);
        chk("reset_hold", obs(), 64'h0);
        Reset = 1'b0;

        run("and_r1r2r3", OP_AND, 4'd1, 4'd2, 4'd3, 15'h0, 0, 1'b0, -1);
        run("wait3",      OP_AND, 4'd1, 4'd2, 4'd3, 15'h0, 3, 1'b0, -1);
        run("timeout",    OP_AND, 4'd1, 4'd2, 4'd3, 15'h0, 0, 1'b1, -1);
        run("mul",        OP_MUL, 4'd0, 4'd4, 4'd5, 15'h0, 0, 1'b0, -1);
        run("not",        OP_NOT, 4'd6, 4'd7, 4'd9, 15'h0, 0, 1'b0, -1);
        run("same_reg",   OP_AND, 4'd15, 4'd15, 4'd15, 15'h7fff, 1, 1'b0, -1);
        run("rst_t4",     OP_AND, 4'd1, 4'd2, 4'd3, 15'h0, 0, 1'b0, 5);
        run("post_rst",   OP_AND, 4'd1, 4'd2, 4'd3, 15'h0, 0, 1'b0, -1);

        for (int n = 0; n < 60; n++) begin
            pick = int'($urandom_range(0, 6));
            case (pick)
                0: opc = OP_MUL;
                1: opc = OP_DIV;
                2: opc = OP_NEG;
                3: opc = OP_NOT;
                default: opc = 5'($urandom);
            endcase
            run($sformatf("rnd%0d", n), opc, 4'($urandom), 4'($urandom), 4'($urandom),
                15'($urandom), int'($urandom_range(0, 5)), ($urandom_range(0, 9) == 0), -1);
        end

        @(negedge Clock);
        bus.Start = 1'b0;
        chk("final_idle", obs(), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
